// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the multiplier-to-adder reduction network nodes.
// A network word is laid out MSB to LSB as:
//   data    : bit_width bits
//   address : log_n_add bits  (destination adder index)
//   control : ctrl_bit bits   (bit 0 is the valid flag)
// No ports (package).
// ---------------------------------------------------------------------------
package noc_pkg;

  // Position of the valid flag inside a word.
  localparam int VALID_IDX = 0;

  // Field offsets for the default network configuration (16/6/1).
  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_LOG_N_ADD = 6;
  localparam int DEF_CTRL_BIT  = 1;
  localparam int DEF_ADDR_LSB  = DEF_CTRL_BIT;
  localparam int DEF_DATA_LSB  = DEF_CTRL_BIT + DEF_LOG_N_ADD;

  // Total word width for a given field configuration.
  function automatic int word_w(input int bit_width, input int log_n_add, input int ctrl_bit);
    return bit_width + log_n_add + ctrl_bit;
  endfunction

  // LSB of the address field.
  function automatic int addr_lsb(input int ctrl_bit);
    return ctrl_bit;
  endfunction

  // LSB of the data field.
  function automatic int data_lsb(input int log_n_add, input int ctrl_bit);
    return log_n_add + ctrl_bit;
  endfunction

endpackage : noc_pkg

// File: rtl/noc_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter_if
// Bundle of the arbiter's data-path and flow-control signals.
//   in    : W*N packed input words, word i = in[i*W +: W]
//   stall : per-input stall, 1 = input must hold its word
//   busy  : downstream cannot accept out this cycle
//   out   : registered output word, out[0] = valid
//   gnt   : one-hot source of the word currently in out
// Modports:
//   master : the environment (upstream sources and downstream sink)
//   slave  : the arbiter node
// ---------------------------------------------------------------------------
interface noc_rr_arbiter_if #(
  parameter int W = 23,
  parameter int N = 4
);

  logic [W*N-1:0] in;
  logic [N-1:0]   stall;
  logic           busy;
  logic [W-1:0]   out;
  logic [N-1:0]   gnt;

  modport master (
    output in,
    output busy,
    input  stall,
    input  out,
    input  gnt
  );

  modport slave (
    input  in,
    input  busy,
    output stall,
    output out,
    output gnt
  );

endinterface : noc_rr_arbiter_if

// File: rtl/noc_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans req starting at index ptr,
// ascending and wrapping from N-1 to 0, and reports the first set index.
//   req : N-bit request vector
//   ptr : scan start index
//   gnt : one-hot of the selected index (all zero when nothing requests)
//   idx : encoded selected index (0 when nothing requests)
//   any : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int LOG_N = 2
) (
  input  logic [(2**LOG_N)-1:0] req,
  input  logic [LOG_N-1:0]      ptr,
  output logic [(2**LOG_N)-1:0] gnt,
  output logic [LOG_N-1:0]      idx,
  output logic                  any
);

  localparam int N = 2**LOG_N;

  logic [LOG_N-1:0] cand_s;

  // Rotating priority scan: the first request found at or after ptr wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int k = 0; k < N; k++) begin
      // Index arithmetic wraps naturally because N is a power of two.
      cand_s = ptr + LOG_N'(k);
      if (!any && req[cand_s]) begin
        any = 1'b1;
        idx = cand_s;
      end else begin
        any = any;
        idx = idx;
      end
    end
    gnt[idx] = any;
  end

endmodule : rr_pick

// File: rtl/noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
// N-way round-robin merge node for the reduction network. Each input owns a
// one-entry holding register; words are moved from the holding registers
// into a single registered output, one per cycle, in round-robin order.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : noc_rr_arbiter_if.slave (in, stall, busy, out, gnt)
// Timing: in valid -> out valid takes two edges when idle with busy low.
// stall is a pure register output, so there is no combinational path from
// in or busy to stall.
// ---------------------------------------------------------------------------
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int log_n_add = 6,
  parameter int ctrl_bit  = 1,
  parameter int log_n_in  = 2
) (
  input logic             clk,
  input logic             rst,
  noc_rr_arbiter_if.slave bus
);

  localparam int N = 2**log_n_in;
  localparam int W = word_w(bit_width, log_n_add, ctrl_bit);
  localparam logic [log_n_in-1:0] PTR_ONE = log_n_in'(1);

  logic [W-1:0]        word_s   [N];
  logic [W-1:0]        hold_r   [N];
  logic [N-1:0]        hf_r;
  logic [N-1:0]        hf_nxt_s;
  logic [N-1:0]        cap_s;
  logic [N-1:0]        clr_s;
  logic [N-1:0]        pick_gnt_s;
  logic [log_n_in-1:0] pick_idx_s;
  logic                pick_any_s;
  logic [log_n_in-1:0] ptr_r;
  logic [W-1:0]        out_r;
  logic [N-1:0]        gnt_r;
  logic                ld_s;

  assign bus.stall = hf_r;
  assign bus.out   = out_r;
  assign bus.gnt   = gnt_r;

  rr_pick #(
    .LOG_N (log_n_in)
  ) u_pick (
    .req (hf_r),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // The output register may be reloaded when it is empty or being drained.
  assign ld_s  = ~out_r[VALID_IDX] | ~bus.busy;
  assign clr_s = (ld_s && pick_any_s) ? pick_gnt_s : {N{1'b0}};

  // Split the packed input bus and decide which inputs are captured.
  always_comb begin
    cap_s = '0;
    for (int i = 0; i < N; i++) begin
      word_s[i] = bus.in[i*W +: W];
      // Only empty slots capture; invalid words are never taken.
      cap_s[i]  = word_s[i][VALID_IDX] & ~hf_r[i];
    end
    // A slot cannot be captured and granted together: capture needs hf=0,
    // grant needs hf=1, both judged on the pre-edge flag.
    hf_nxt_s = (hf_r | cap_s) & ~clr_s;
  end

  // Holding registers and their occupancy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hf_r <= '0;
      for (int i = 0; i < N; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      hf_r <= hf_nxt_s;
      for (int i = 0; i < N; i++) begin
        if (cap_s[i]) begin
          hold_r[i] <= word_s[i];
        end else begin
          hold_r[i] <= hold_r[i];
        end
      end
    end
  end

  // Output word, grant vector and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= '0;
      gnt_r <= '0;
      ptr_r <= '0;
    end else if (ld_s) begin
      if (pick_any_s) begin
        out_r <= hold_r[pick_idx_s];
        gnt_r <= pick_gnt_s;
        // Next scan starts just past the winner; wraps since N = 2**log_n_in.
        ptr_r <= pick_idx_s + PTR_ONE;
      end else begin
        out_r <= '0;
        gnt_r <= '0;
        ptr_r <= ptr_r;
      end
    end else begin
      // Downstream busy with a valid word: hold everything stable.
      out_r <= out_r;
      gnt_r <= gnt_r;
      ptr_r <= ptr_r;
    end
  end

endmodule : noc_rr_arbiter

// File: tb/tb_noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_rr_arbiter
// Directed bench for noc_rr_arbiter with N=4, W=23. Inputs are driven one
// time unit after the rising edge; outputs are checked at that same point,
// i.e. well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_noc_rr_arbiter;

  localparam int N = 4;
  localparam int W = 23;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  noc_rr_arbiter_if #(.W(W), .N(N)) bus ();

  noc_rr_arbiter #(
    .bit_width (16),
    .log_n_add (6),
    .ctrl_bit  (1),
    .log_n_in  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mkw(input logic [15:0] d, input logic [5:0] a, input logic v);
    return {d, a, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic [W-1:0] w2, input logic [W-1:0] w3);
    bus.in = {w3, w2, w1, w0};
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] o, input logic [3:0] g, input logic [3:0] s);
    chk({tag, "_out"},   bus.out,   o);
    chk({tag, "_gnt"},   bus.gnt,   {19'd0, g});
    chk({tag, "_stall"}, bus.stall, {19'd0, s});
  endtask

  logic [W-1:0] zw;
  logic [W-1:0] a2, p0, p1, p3, q0, q3, y0, y3, z0, z1, z3, bad0, x2, b3, c0, c3;
  logic [W-1:0] rr_w   [4];
  logic [3:0]   rr_gnt [8];
  logic [3:0]   rr_stl [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    zw    = '0;
    a2    = mkw(16'h1234, 6'd5,  1'b1);
    c0    = mkw(16'h0C00, 6'd1,  1'b1);
    c3    = mkw(16'h0C03, 6'd2,  1'b1);
    b3    = mkw(16'h0B03, 6'd3,  1'b1);
    p0    = mkw(16'hA000, 6'd10, 1'b1);
    p1    = mkw(16'hA001, 6'd11, 1'b1);
    p3    = mkw(16'hA003, 6'd13, 1'b1);
    bad0  = mkw(16'hFFFF, 6'd0,  1'b0);
    x2    = mkw(16'h5502, 6'd20, 1'b1);
    y0    = mkw(16'h6600, 6'd30, 1'b1);
    y3    = mkw(16'h6603, 6'd33, 1'b1);
    z0    = mkw(16'h7700, 6'd40, 1'b1);
    z1    = mkw(16'h7701, 6'd41, 1'b1);
    z3    = mkw(16'h7703, 6'd43, 1'b1);
    q0    = mkw(16'h8800, 6'd50, 1'b1);
    q3    = mkw(16'h8803, 6'd53, 1'b1);
    rr_w[0] = mkw(16'h1000, 6'd0, 1'b1);
    rr_w[1] = mkw(16'h2001, 6'd1, 1'b1);
    rr_w[2] = mkw(16'h3002, 6'd2, 1'b1);
    rr_w[3] = mkw(16'h4003, 6'd3, 1'b1);
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rr_stl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    rst      = 1'b0;
    bus.busy = 1'b0;
    bus.in   = '0;
    tick();
    tick();
    chk_all("reset", zw, 4'b0000, 4'b0000);
    rst = 1'b1;

    // Single path: input 2, one cycle, two-edge latency.
    tick();
    set_in(zw, zw, a2, zw);
    tick();
    chk_all("single_e1", zw, 4'b0000, 4'b0100);
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("single_e2", a2, 4'b0100, 4'b0000);
    tick();
    chk_all("single_e3", zw, 4'b0000, 4'b0000);

    // Pointer is now 3: with 0 and 3 both pending, 3 must win first.
    set_in(c0, zw, zw, c3);
    tick();
    chk_all("ptr3_e1", zw, 4'b0000, 4'b1001);
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("ptr3_e2", c3, 4'b1000, 4'b0001);
    tick();
    chk_all("ptr3_e3", c0, 4'b0001, 4'b0000);
    // Pointer 1; a lone input-3 word brings it back to 0.
    set_in(zw, zw, zw, b3);
    tick();
    chk_all("to0_e1", zw, 4'b0000, 4'b1000);
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("to0_e2", b3, 4'b1000, 4'b0000);
    tick();
    chk_all("to0_e3", zw, 4'b0000, 4'b0000);

    // Round robin: all four inputs present continuously from ptr=0.
    set_in(rr_w[0], rr_w[1], rr_w[2], rr_w[3]);
    tick();
    chk_all("rr_e1", zw, 4'b0000, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all($sformatf("rr_%0d", k), rr_w[k % 4], rr_gnt[k], rr_stl[k]);
      if (k == 4) set_in(zw, zw, zw, zw);
    end
    tick();
    chk_all("rr_idle", zw, 4'b0000, 4'b0000);

    // Back-pressure: input-1 word stuck in out while 0 and 3 arrive.
    set_in(zw, p1, zw, zw);
    tick();
    chk_all("bp_e1", zw, 4'b0000, 4'b0010);
    set_in(zw, zw, zw, zw);
    bus.busy = 1'b1;
    tick();
    chk_all("bp_e2", p1, 4'b0010, 4'b0000);
    set_in(p0, zw, zw, p3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all($sformatf("bp_hold_%0d", k), p1, 4'b0010, 4'b1001);
      if (k == 0) set_in(zw, zw, zw, zw);
    end
    bus.busy = 1'b0;
    tick();
    chk_all("bp_rel1", p3, 4'b1000, 4'b0001);
    tick();
    chk_all("bp_rel2", p0, 4'b0001, 4'b0000);
    tick();
    chk_all("bp_idle", zw, 4'b0000, 4'b0000);

    // Invalid words are never captured.
    set_in(bad0, zw, zw, zw);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("inv_%0d", k), zw, 4'b0000, 4'b0000);
    end
    set_in(zw, zw, zw, zw);

    // Pointer 1 -> 3 via a lone input-2 word.
    set_in(zw, zw, x2, zw);
    tick();
    chk_all("to3_e1", zw, 4'b0000, 4'b0100);
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("to3_e2", x2, 4'b0100, 4'b0000);
    tick();

    // Wrap and fairness: inputs 0 and 3 alternate starting with 3.
    set_in(y0, zw, zw, y3);
    tick();
    chk_all("wrap_e1", zw, 4'b0000, 4'b1001);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) chk_all($sformatf("wrap_%0d", k), y3, 4'b1000, 4'b0001);
      else            chk_all($sformatf("wrap_%0d", k), y0, 4'b0001, 4'b1000);
    end
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("wrap_tail", y3, 4'b1000, 4'b0000);
    tick();
    chk_all("wrap_idle", zw, 4'b0000, 4'b0000);

    // Asynchronous reset mid-stream with hf=1011 and out valid.
    set_in(z0, z1, zw, z3);
    tick();
    chk_all("ar_e1", zw, 4'b0000, 4'b1011);
    set_in(z0, zw, zw, zw);
    bus.busy = 1'b1;
    tick();
    chk_all("ar_e2", z0, 4'b0001, 4'b1010);
    tick();
    chk_all("ar_e3", z0, 4'b0001, 4'b1011);
    set_in(zw, zw, zw, zw);
    #2;
    rst = 1'b0;
    #1;
    chk_all("ar_async", zw, 4'b0000, 4'b0000);
    tick();
    chk_all("ar_during", zw, 4'b0000, 4'b0000);
    rst      = 1'b1;
    bus.busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("ar_idle_%0d", k), zw, 4'b0000, 4'b0000);
    end

    // Pointer returned to 0: input 0 beats input 3.
    set_in(q0, zw, zw, q3);
    tick();
    chk_all("pr_e1", zw, 4'b0000, 4'b1001);
    set_in(zw, zw, zw, zw);
    tick();
    chk_all("pr_e2", q0, 4'b0001, 4'b1000);
    tick();
    chk_all("pr_e3", q3, 4'b1000, 4'b0000);
    tick();
    chk_all("pr_idle", zw, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_noc_rr_arbiter
